fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch controller for the five-stage pipeline. It drives the address into the synchronous-read instruction memory, pairs each returned word with its PC and presents it to IF/ID with a valid flag. It handles pipeline stalls by replaying the held address, and squashes wrong-path fetches on branch/jump redirects. It stops cleanly at the end of the loaded program.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after start; byte address, word aligned.
- PROG_BYTES, 104: program size in bytes (26 words). Addresses >= PROG_BYTES are out of program.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins fetching from RESET_PC; honoured only in IDLE.
- stall  in  1  IF/ID hold request from the hazard unit.
- redirect  in  1  branch/jump taken; has priority over stall.
- redirect_pc  in  32  target byte address; bits [1:0] are ignored (treated as 0).
- imem_pc  out  32  address to instruction memory; combinational; the memory samples it on posedge.
- imem_instr  in  32  memory read data; holds the word addressed at the previous posedge.
- if_pc  out  32  PC of the presented instruction (= req_pc).
- if_instr  out  32  presented instruction (= imem_instr, passthrough).
- if_valid  out  1  if_pc/if_instr are a real, in-path instruction.
- halted  out  1  high in HALT state.
- fetch_count  out  32  count of instructions accepted by IF/ID; wraps mod 2^32.

## Operation
- Internal registers:
  - pc_reg: next address to issue.
  - req_pc / req_valid: the address the memory sampled at the last edge, and whether it is a live fetch.
  - state: IDLE, RUN or HALT.
  - fetch_count.
- Reset values:
  - pc_reg = req_pc = RESET_PC, req_valid = 0, state = IDLE, fetch_count = 0.
  - Resulting outputs: if_valid = 0, halted = 0, imem_pc = RESET_PC, if_pc = RESET_PC.
- tgt = {redirect_pc[31:2], 2'b00}.
- imem_pc mux, in priority order:
  1. redirect in RUN/HALT: tgt.
  2. Otherwise stall in RUN: req_pc.
  3. Otherwise: pc_reg.
- if_valid = req_valid & ~redirect.
- Accept = if_valid & ~stall. fetch_count increments on each accept.
- IDLE:
  - stall and redirect are ignored.
  - start: req_pc <= pc_reg, req_valid <= 1, pc_reg <= pc_reg+4, go to RUN.
- RUN, redirect (wins over stall):
  - If tgt < PROG_BYTES: req_pc <= tgt, req_valid <= 1, pc_reg <= tgt+4; stay in RUN.
  - Otherwise: req_valid <= 0, pc_reg <= tgt; go to HALT.
- RUN, stall without redirect: all registers hold. The memory re-reads req_pc, so if_instr stays stable.
- RUN, neither redirect nor stall:
  - If pc_reg < PROG_BYTES: req_pc <= pc_reg, req_valid <= 1, pc_reg += 4.
  - Otherwise: req_valid <= 0; go to HALT.
- HALT:
  - No issue; if_valid = 0.
  - Redirect follows the same rules as in RUN. An in-range tgt returns the block to RUN.
  - start is ignored.
- rst in any state, including mid-stall or mid-redirect, overrides everything and restores reset values at that edge.
- Address arithmetic is unsigned 32-bit; pc_reg+4 wraps at 2^32. The compare with PROG_BYTES is unsigned.

## Timing
- Memory latency is 1 cycle: an address issued at edge N appears on imem_instr/if_instr during cycle N+1.
- Start to first valid instruction: 1 cycle (start sampled at edge N; if_valid = 1 from cycle N+1 with if_pc = RESET_PC).
- Steady state: one instruction per cycle; if_pc advances by 4 each unstalled cycle.
- Stall:
  - if_pc, if_instr and if_valid hold for every stalled cycle.
  - After stall drops, the next instruction appears in the following cycle with no bubble.
- Redirect asserted in cycle N:
  - if_valid = 0 in cycle N; the wrong-path instruction is squashed and not counted.
  - Target instruction is valid in cycle N+1 (1-cycle penalty).
- Redirect and stall in the same cycle: the redirect is taken and the stall is ignored for fetch.
- End of program: the last word (PROG_BYTES-4) is presented until it is accepted. halted = 1 from the following cycle; if_valid = 0 thereafter.
- Back-to-back redirects: each one applies on its own; only the final target's word is presented.

## Test plan
- Reset, pulse start, never stall:
  - Required: if_pc = 0,4,…,100 on 26 consecutive cycles with if_instr = mem[k].
  - Then halted = 1 and fetch_count = 26.
- Stall 3 cycles while if_pc = 8:
  - Required: imem_pc = 8, if_pc = 8 and if_instr = mem[2] hold; fetch_count does not increment.
  - The cycle after stall drops: if_pc = 12.
- Redirect to 0x14 while if_pc = 0x0C:
  - Required: if_valid = 0 that cycle, and the 0x0C word is not counted.
  - Next cycle: if_pc = 0x14, then 0x18.
- Redirect to 0x04 together with stall:
  - Required: redirect wins; imem_pc = 0x04 that cycle, if_pc = 0x04 and valid in the next cycle.
- Redirect to 0x70 (112 >= 104):
  - Required: halted = 1 and if_valid = 0 from the next cycle.
  - Then redirect to 0x13 in HALT: state returns to RUN and if_pc = 0x10 the following cycle (low bits dropped).
- rst asserted mid-run at if_pc = 0x30:
  - Required at the next cycle: if_valid = 0, halted = 0, fetch_count = 0, imem_pc = RESET_PC; start is required before fetching resumes.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch: issues PCs to a 1-cycle sync imem, pairs returned word with its PC for IF/ID.
// Latency 1 cycle (address at edge N, word in cycle N+1); stall replays the held address, redirect squashes.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned PROG_BYTES = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [31:0] PROG_END = 32'(PROG_BYTES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] tgt;
  logic        active;
  logic        accept;

  always_comb begin
    tgt      = {redirect_pc[31:2], 2'b00};
    active   = (state_q != IDLE);
    if_valid = req_valid_q & ~redirect;
    accept   = if_valid & ~stall;

    if (redirect && active) begin
      imem_pc = tgt;
    end else if (stall && state_q == RUN) begin
      imem_pc = req_pc_q;
    end else begin
      imem_pc = pc_q;
    end

    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    req_valid_d   = req_valid_q;
    fetch_count_d = accept ? fetch_count_q + 32'd1 : fetch_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          req_pc_d    = pc_q;
          req_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
          state_d     = RUN;
        end
      end
      RUN, HALT: begin
        // A redirect outranks stall and is also the only way out of HALT.
        if (redirect) begin
          if (tgt < PROG_END) begin
            req_pc_d    = tgt;
            req_valid_d = 1'b1;
            pc_d        = tgt + 32'd4;
            state_d     = RUN;
          end else begin
            req_valid_d = 1'b0;
            pc_d        = tgt;
            state_d     = HALT;
          end
        end else if (state_q == RUN && !stall) begin
          if (pc_q < PROG_END) begin
            req_pc_d    = pc_q;
            req_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
          end else begin
            req_valid_d = 1'b0;
            state_d     = HALT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      req_valid_q   <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      req_valid_q   <= req_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign if_pc       = req_pc_q;
  assign if_instr    = imem_instr;
  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;

endmodule
